// File: rtl/load_rs_param.sv
// Load reservation station: collapsing queue of DEPTH loads, dual-CDB operand snooping and
// oldest-ready issue. Define LOAD_RS_ALIGN_CHECK_EN to register a misalignment flag per issued load.
module load_rs_param #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ROB_W  = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,

    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [2:0]                   disp_sub_type,
    input  logic [DATA_W-1:0]            disp_base,
    input  logic                         disp_base_pend,
    input  logic [ROB_W-1:0]             disp_base_q,
    input  logic [DATA_W-1:0]            disp_offset,
    input  logic [ROB_W-1:0]             disp_rob,

    input  logic                         cdb0_valid,
    input  logic [ROB_W-1:0]             cdb0_rob,
    input  logic [DATA_W-1:0]            cdb0_data,
    input  logic                         cdb1_valid,
    input  logic [ROB_W-1:0]             cdb1_rob,
    input  logic [DATA_W-1:0]            cdb1_data,

    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [DATA_W-1:0]            issue_addr,
    output logic [2:0]                   issue_type,
    output logic [ROB_W-1:0]             issue_rob,
    output logic                         issue_misaligned,

    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    localparam logic [2:0] TypeLh  = 3'b001;
    localparam logic [2:0] TypeLw  = 3'b010;
    localparam logic [2:0] TypeLhu = 3'b101;

    // Queue storage; entry 0 is the oldest, valid entries are indices below count_q.
    logic              ent_pend_q [DEPTH];
    logic [ROB_W-1:0]  ent_tag_q  [DEPTH];
    logic [DATA_W-1:0] ent_base_q [DEPTH];
    logic [DATA_W-1:0] ent_off_q  [DEPTH];
    logic [2:0]        ent_type_q [DEPTH];
    logic [ROB_W-1:0]  ent_rob_q  [DEPTH];
    logic [CNT_W-1:0]  count_q;

    logic              ent_pend_d [DEPTH];
    logic [ROB_W-1:0]  ent_tag_d  [DEPTH];
    logic [DATA_W-1:0] ent_base_d [DEPTH];
    logic [DATA_W-1:0] ent_off_d  [DEPTH];
    logic [2:0]        ent_type_d [DEPTH];
    logic [ROB_W-1:0]  ent_rob_d  [DEPTH];
    logic [CNT_W-1:0]  count_d;

    // Entry state after this cycle's CDB snoop, before the shift.
    logic              wk_pend [DEPTH];
    logic [DATA_W-1:0] wk_base [DEPTH];

    logic              disp_acc;
    logic              disp_pend_w;
    logic [DATA_W-1:0] disp_base_w;

    logic              ready     [DEPTH];
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic [DATA_W-1:0] sel_addr;
    logic              do_issue;
    logic [CNT_W-1:0]  cnt_rem;

    logic              issue_valid_q;
    logic [DATA_W-1:0] issue_addr_q;
    logic [2:0]        issue_type_q;
    logic [ROB_W-1:0]  issue_rob_q;

    assign disp_ready = count_q < CNT_W'(DEPTH);
    assign disp_acc   = disp_valid && disp_ready;
    assign occupancy  = count_q;

    // Dispatch bypass: a base produced on the CDB in the dispatch cycle is captured directly.
    always_comb begin
        disp_pend_w = disp_base_pend;
        disp_base_w = disp_base;
        if (disp_base_pend) begin
            if (cdb0_valid && cdb0_rob == disp_base_q) begin
                disp_pend_w = 1'b0;
                disp_base_w = cdb0_data;
            end else if (cdb1_valid && cdb1_rob == disp_base_q) begin
                disp_pend_w = 1'b0;
                disp_base_w = cdb1_data;
            end
        end
    end

    // Wakeup; cdb0 wins when both ports carry the awaited tag.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            wk_pend[i] = ent_pend_q[i];
            wk_base[i] = ent_base_q[i];
            if (ent_pend_q[i]) begin
                if (cdb0_valid && cdb0_rob == ent_tag_q[i]) begin
                    wk_pend[i] = 1'b0;
                    wk_base[i] = cdb0_data;
                end else if (cdb1_valid && cdb1_rob == ent_tag_q[i]) begin
                    wk_pend[i] = 1'b0;
                    wk_base[i] = cdb1_data;
                end
            end
        end
    end

    // Oldest-ready select uses registered pend only, so a wakeup is visible one cycle later.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ready[i] = (CNT_W'(i) < count_q) && !ent_pend_q[i];
        end
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign sel_addr = ent_base_q[sel_idx] + ent_off_q[sel_idx];
    assign do_issue = (!issue_valid_q || issue_ready) && sel_found;
    assign cnt_rem  = count_q - CNT_W'(do_issue);

    // Remove the issued entry first, then append the dispatch at the new tail.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            int src;
            src = i;
            if (do_issue && i >= int'(sel_idx) && i < int'(DEPTH) - 1) begin
                src = i + 1;
            end
            ent_pend_d[i] = wk_pend[src];
            ent_tag_d[i]  = ent_tag_q[src];
            ent_base_d[i] = wk_base[src];
            ent_off_d[i]  = ent_off_q[src];
            ent_type_d[i] = ent_type_q[src];
            ent_rob_d[i]  = ent_rob_q[src];
            if (disp_acc && cnt_rem == CNT_W'(i)) begin
                ent_pend_d[i] = disp_pend_w;
                ent_tag_d[i]  = disp_base_q;
                ent_base_d[i] = disp_base_w;
                ent_off_d[i]  = disp_offset;
                ent_type_d[i] = disp_sub_type;
                ent_rob_d[i]  = disp_rob;
            end
        end
        count_d = cnt_rem + CNT_W'(disp_acc);
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_pend_q[i] <= 1'b0;
                ent_tag_q[i]  <= '0;
                ent_base_q[i] <= '0;
                ent_off_q[i]  <= '0;
                ent_type_q[i] <= '0;
                ent_rob_q[i]  <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_pend_q[i] <= ent_pend_d[i];
                ent_tag_q[i]  <= ent_tag_d[i];
                ent_base_q[i] <= ent_base_d[i];
                ent_off_q[i]  <= ent_off_d[i];
                ent_type_q[i] <= ent_type_d[i];
                ent_rob_q[i]  <= ent_rob_d[i];
            end
        end
    end

    // Issue register: holds until the load unit samples issue_ready high.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            issue_valid_q <= 1'b0;
            issue_addr_q  <= '0;
            issue_type_q  <= '0;
            issue_rob_q   <= '0;
        end else if (do_issue) begin
            issue_valid_q <= 1'b1;
            issue_addr_q  <= sel_addr;
            issue_type_q  <= ent_type_q[sel_idx];
            issue_rob_q   <= ent_rob_q[sel_idx];
        end else if (issue_ready) begin
            issue_valid_q <= 1'b0;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_addr  = issue_addr_q;
    assign issue_type  = issue_type_q;
    assign issue_rob   = issue_rob_q;

`ifdef LOAD_RS_ALIGN_CHECK_EN
    logic sel_misaligned;
    logic issue_mis_q;

    always_comb begin
        unique case (ent_type_q[sel_idx])
            TypeLw:          sel_misaligned = sel_addr[1:0] != 2'b00;
            TypeLh, TypeLhu: sel_misaligned = sel_addr[0];
            default:         sel_misaligned = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            issue_mis_q <= 1'b0;
        end else if (do_issue) begin
            issue_mis_q <= sel_misaligned;
        end
    end

    assign issue_misaligned = issue_mis_q;
`else
    assign issue_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_load_rs_param.sv
// Directed bench for load_rs_param: expected issues are queued as loads become resolvable
// and popped as the DUT presents them to the load unit.
module tb_load_rs_param;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  typ;
        logic [5:0]  rob;
        logic        mis;
    } exp_t;

`ifdef LOAD_RS_ALIGN_CHECK_EN
    localparam bit Align = 1'b1;
`else
    localparam bit Align = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, flush;
    logic        disp_valid, disp_ready, disp_base_pend;
    logic [2:0]  disp_sub_type;
    logic [31:0] disp_base, disp_offset;
    logic [5:0]  disp_base_q, disp_rob;
    logic        cdb0_valid, cdb1_valid;
    logic [5:0]  cdb0_rob, cdb1_rob;
    logic [31:0] cdb0_data, cdb1_data;
    logic        issue_valid, issue_ready, issue_misaligned;
    logic [31:0] issue_addr;
    logic [2:0]  issue_type;
    logic [5:0]  issue_rob;
    logic [2:0]  occupancy;

    int   checks = 0;
    int   errors = 0;
    int   waited;
    exp_t sb[$];

    load_rs_param dut (
        .clock(clock), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_sub_type(disp_sub_type),
        .disp_base(disp_base), .disp_base_pend(disp_base_pend), .disp_base_q(disp_base_q),
        .disp_offset(disp_offset), .disp_rob(disp_rob),
        .cdb0_valid(cdb0_valid), .cdb0_rob(cdb0_rob), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_rob(cdb1_rob), .cdb1_data(cdb1_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_addr(issue_addr),
        .issue_type(issue_type), .issue_rob(issue_rob), .issue_misaligned(issue_misaligned),
        .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] addr, input logic [2:0] t,
                                input logic [5:0] rob);
        exp_t e;
        e.addr = addr;
        e.typ  = t;
        e.rob  = rob;
        e.mis  = Align && ((t == 3'b010 && addr[1:0] != 2'b00) ||
                           ((t == 3'b001 || t == 3'b101) && addr[0]));
        return e;
    endfunction

    task automatic dispatch(input logic [2:0] t, input logic [31:0] base, input logic pend,
                            input logic [5:0] q, input logic [31:0] off, input logic [5:0] rob);
        disp_valid     = 1'b1;
        disp_sub_type  = t;
        disp_base      = base;
        disp_base_pend = pend;
        disp_base_q    = q;
        disp_offset    = off;
        disp_rob       = rob;
        step();
        disp_valid     = 1'b0;
    endtask

    // Waits (bounded) for issue_valid, checks against the scoreboard head, then completes
    // the handshake edge; issue_ready must be high when called.
    task automatic wait_issue(input string name, output int w);
        exp_t e;
        w = 0;
        while (issue_valid !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        check({name, "_valid"}, 64'(issue_valid), 64'(1));
        if (issue_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            check({name, "_addr"}, 64'(issue_addr), 64'(e.addr));
            check({name, "_type"}, 64'(issue_type), 64'(e.typ));
            check({name, "_rob"},  64'(issue_rob),  64'(e.rob));
            check({name, "_mis"},  64'(issue_misaligned), 64'(e.mis));
        end
        step();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_sub_type = '0;
        disp_base = '0; disp_base_pend = 1'b0; disp_base_q = '0; disp_offset = '0;
        disp_rob = '0; cdb0_valid = 1'b0; cdb0_rob = '0; cdb0_data = '0;
        cdb1_valid = 1'b0; cdb1_rob = '0; cdb1_data = '0; issue_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_issue_valid", 64'(issue_valid), 64'(0));
        check("rst_occupancy", 64'(occupancy), 64'(0));
        check("rst_disp_ready", 64'(disp_ready), 64'(1));
        check("rst_issue_addr", 64'(issue_addr), 64'(0));
        check("rst_misaligned", 64'(issue_misaligned), 64'(0));

        // Basic LW, one-cycle latency.
        issue_ready = 1'b1;
        sb.push_back(mk(32'h108, 3'b010, 6'd3));
        dispatch(3'b010, 32'h100, 1'b0, 6'd0, 32'h8, 6'd3);
        check("t1_occ_after_disp", 64'(occupancy), 64'(1));
        wait_issue("t1", waited);
        check("t1_latency", 64'(waited), 64'(1));
        check("t1_occ_after_issue", 64'(occupancy), 64'(0));
        check("t1_valid_falls", 64'(issue_valid), 64'(0));

        // Younger ready load overtakes an older pending one.
        dispatch(3'b010, 32'hDEAD, 1'b1, 6'd5, 32'h10, 6'd10);
        sb.push_back(mk(32'h20, 3'b100, 6'd11));
        dispatch(3'b100, 32'h20, 1'b0, 6'd0, 32'h0, 6'd11);
        wait_issue("t2_b", waited);
        check("t2_occ", 64'(occupancy), 64'(1));
        cdb1_valid = 1'b1; cdb1_rob = 6'd5; cdb1_data = 32'h40;
        sb.push_back(mk(32'h50, 3'b010, 6'd10));
        step();
        cdb1_valid = 1'b0;
        check("t2_no_issue_same_cycle", 64'(issue_valid), 64'(0));
        wait_issue("t2_a", waited);
        check("t2_a_latency", 64'(waited), 64'(1));

        // Fill, ignored fifth dispatch, middle-entry issue and collapse.
        for (int i = 0; i < 4; i++) begin
            dispatch(3'b010, 32'hBAD0, 1'b1, 6'(20 + i), 32'(4 * i), 6'(30 + i));
        end
        check("t3_full_occ", 64'(occupancy), 64'(4));
        check("t3_full_ready", 64'(disp_ready), 64'(0));
        dispatch(3'b010, 32'h7000, 1'b0, 6'd0, 32'h0, 6'd40);
        check("t3_ignored_occ", 64'(occupancy), 64'(4));
        cdb0_valid = 1'b1; cdb0_rob = 6'd22; cdb0_data = 32'h200;
        sb.push_back(mk(32'h208, 3'b010, 6'd32));
        step();
        cdb0_valid = 1'b0;
        check("t3_wake_occ", 64'(occupancy), 64'(4));
        check("t3_wake_ready", 64'(disp_ready), 64'(0));
        wait_issue("t3_e2", waited);
        check("t3_occ3", 64'(occupancy), 64'(3));
        check("t3_ready_again", 64'(disp_ready), 64'(1));
        cdb0_valid = 1'b1; cdb0_rob = 6'd23; cdb0_data = 32'h300;
        cdb1_valid = 1'b1; cdb1_rob = 6'd21; cdb1_data = 32'h100;
        sb.push_back(mk(32'h104, 3'b010, 6'd31));
        sb.push_back(mk(32'h30C, 3'b010, 6'd33));
        step();
        cdb0_valid = 1'b0; cdb1_valid = 1'b0;
        wait_issue("t3_e1", waited);
        wait_issue("t3_e3", waited);
        check("t3_back_to_back", 64'(waited), 64'(0));
        check("t3_occ1", 64'(occupancy), 64'(1));
        cdb0_valid = 1'b1; cdb0_rob = 6'd20; cdb0_data = 32'h0;
        sb.push_back(mk(32'h0, 3'b010, 6'd30));
        step();
        cdb0_valid = 1'b0;
        wait_issue("t3_e0", waited);

        // Both CDB ports match: cdb0 wins.
        dispatch(3'b100, 32'h0, 1'b1, 6'd9, 32'h0, 6'd12);
        cdb0_valid = 1'b1; cdb0_rob = 6'd9; cdb0_data = 32'h111;
        cdb1_valid = 1'b1; cdb1_rob = 6'd9; cdb1_data = 32'h222;
        sb.push_back(mk(32'h111, 3'b100, 6'd12));
        step();
        cdb0_valid = 1'b0; cdb1_valid = 1'b0;
        wait_issue("prio", waited);

        // Dispatch bypass with address wrap.
        cdb0_valid = 1'b1; cdb0_rob = 6'd7; cdb0_data = 32'hFFFF_FFFC;
        sb.push_back(mk(32'h4, 3'b010, 6'd14));
        dispatch(3'b010, 32'h0, 1'b1, 6'd7, 32'h8, 6'd14);
        cdb0_valid = 1'b0;
        wait_issue("bypass", waited);
        check("bypass_latency", 64'(waited), 64'(1));

        // Hold with issue_ready low, then alignment cases.
        issue_ready = 1'b0;
        sb.push_back(mk(32'h101, 3'b001, 6'd15));
        dispatch(3'b001, 32'h100, 1'b0, 6'd0, 32'h1, 6'd15);
        sb.push_back(mk(32'h104, 3'b010, 6'd16));
        dispatch(3'b010, 32'h104, 1'b0, 6'd0, 32'h0, 6'd16);
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", 64'(issue_valid), 64'(1));
            check("hold_addr", 64'(issue_addr), 64'(sb[0].addr));
            check("hold_rob", 64'(issue_rob), 64'(sb[0].rob));
            step();
        end
        issue_ready = 1'b1;
        wait_issue("align_lh", waited);
        wait_issue("align_lw", waited);

        // Flush with a held load and a same-cycle dispatch.
        issue_ready = 1'b0;
        dispatch(3'b010, 32'h400, 1'b0, 6'd0, 32'h0, 6'd20);
        dispatch(3'b010, 32'h500, 1'b0, 6'd0, 32'h0, 6'd21);
        check("pre_flush_valid", 64'(issue_valid), 64'(1));
        flush = 1'b1;
        dispatch(3'b010, 32'h600, 1'b0, 6'd0, 32'h0, 6'd22);
        flush = 1'b0;
        check("flush_valid", 64'(issue_valid), 64'(0));
        check("flush_occ", 64'(occupancy), 64'(0));
        check("flush_ready", 64'(disp_ready), 64'(1));
        check("flush_addr", 64'(issue_addr), 64'(0));
        check("flush_rob", 64'(issue_rob), 64'(0));
        check("flush_type", 64'(issue_type), 64'(0));
        step();
        check("flush_drop_disp", 64'(issue_valid), 64'(0));

        // Reset abandons a held load.
        dispatch(3'b010, 32'h700, 1'b0, 6'd0, 32'h0, 6'd23);
        step();
        check("pre_reset_valid", 64'(issue_valid), 64'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_valid", 64'(issue_valid), 64'(0));
        check("reset_occ", 64'(occupancy), 64'(0));

        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_rs_param.md
Name: load_rs_param

Overview:
- Parametrised load reservation station for the Tomasulo core.
- Buffers up to DEPTH load micro-ops dispatched from decode/ROB and resolves each pending base-register operand by snooping both CDB ports.
- Issues ready loads oldest-first to the load unit over a valid/ready handshake, with effective address computed.
- Supports pipeline flush.

Parameters:
- DEPTH, 4, number of entries (>=2).
- ROB_W, 6, ROB tag width.
- DATA_W, 32, operand/address width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- flush  in  1  synchronous squash of all entries and the issue register.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  high when occupancy < DEPTH.
- disp_sub_type  in  3  funct3: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- disp_base  in  DATA_W  base value, valid when disp_base_pend=0.
- disp_base_pend  in  1  base not yet available; wait on disp_base_q.
- disp_base_q  in  ROB_W  producer ROB tag of base.
- disp_offset  in  DATA_W  sign-extended immediate.
- disp_rob  in  ROB_W  destination ROB tag.
- cdb0_valid, cdb1_valid  in  1  CDB broadcast strobes.
- cdb0_rob, cdb1_rob  in  ROB_W  broadcast tags.
- cdb0_data, cdb1_data  in  DATA_W  broadcast values.
- issue_valid  out  1  load presented to the load unit.
- issue_ready  in  1  load unit accepts.
- issue_addr  out  DATA_W  effective address.
- issue_type  out  3  funct3 of the issued load.
- issue_rob  out  ROB_W  destination tag.
- issue_misaligned  out  1  see Optional Feature.
- occupancy  out  clog2(DEPTH+1)  valid entries in the queue (excludes the issue register).

Behaviour:
- Reset (synchronous, active-high) or flush: all entries invalid; occupancy=0; issue_valid=0; issue_addr/type/rob=0; issue_misaligned=0; disp_ready=1 on the following cycle. Any dispatch in the same cycle is dropped. Reset mid-handshake abandons the held load.
- Storage: collapsing queue. Entry 0 is the oldest; new entries append at index occupancy.
- Entry fields: pend, q, base, offset, type, rob.
- Dispatch accepted when disp_valid && disp_ready. disp_ready is derived from registered occupancy only; a slot freed by issue in the same cycle is not usable until the next cycle.
- Dispatch bypass: if disp_base_pend=1 and either CDB carries disp_base_q in the same cycle, the entry is written with pend=0 and that CDB's data.
- Wakeup: each cycle, every pend=1 entry whose q matches cdb0_rob (with cdb0_valid) or cdb1_rob (with cdb1_valid) captures the data and clears pend. If both ports match, cdb0 takes priority.
- Ready rule: an entry is ready when pend=0 in registered state. An entry woken in cycle N is selectable in N+1.
- Select: lowest-index ready entry.
- Issue register load condition: (!issue_valid || issue_ready) && a ready entry exists.
  - issue_addr = base + offset, modulo 2^DATA_W, carry discarded.
  - Type and rob are copied from the selected entry.
  - The entry is removed; higher entries shift down one index, preserving order and any same-cycle wakeup captured.
- Handshake: issue_valid holds, with all issue_* outputs stable, until issue_ready is sampled high. Back-to-back issue every cycle is possible.
- Simultaneous dispatch + issue: the removal shift happens first, then the append. Occupancy is unchanged.
- Latency: a load dispatched with base ready in cycle N shows issue_valid at N+1 at the earliest (queue write at N, select at N+1 edge).
- Full: disp_ready=0; disp_valid is ignored without side effects.
- Empty with no ready entry: issue_valid falls after a handshake completes.

Optional Feature:
- Macro: LOAD_RS_ALIGN_CHECK_EN.
- Defined: issue_misaligned is registered with the issue register.
  - Set to 1 when type is LW and addr[1:0]!=0, or type is LH/LHU and addr[0]!=0.
  - LB/LBU always give 0.
  - The load is still issued.
- Undefined: issue_misaligned is constant 0 and no check logic is built.

Test Plan:
- Reset, then dispatch LW with base=0x100, offset=0x8, rob=3, pend=0, issue_ready=1 -> issue_valid next cycle with addr=0x108, type=010, rob=3; occupancy returns to 0.
- Dispatch A (pend, q=5) then B (ready, base=0x20, offset=0) -> B issues first. cdb1_valid with rob=5, data=0x40 -> A issues with addr=0x40+offset one cycle after the broadcast.
- Fill DEPTH=4 entries, all pend -> disp_ready=0. A fifth disp_valid is ignored and occupancy stays 4. cdb0 matches entry 2 -> entry 2 issues, entry 3 shifts to index 2, disp_ready=1 the following cycle.
- Dispatch with pend=1, q=7 while cdb0_valid, rob=7, data=0xFFFFFFFC, offset=8 -> entry stored ready (bypass), issues with addr=0x00000004 (wrap).
- Hold issue_ready=0 for 3 cycles with issue_valid=1 -> outputs stable. Assert flush -> issue_valid=0 and occupancy=0 next cycle.
- With LOAD_RS_ALIGN_CHECK_EN: LH to addr 0x101 -> issue_misaligned=1. LW to 0x104 -> 0. Without the macro both give 0.
